// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusyI,
        StBusyD
    } arb_state_e;

    localparam int unsigned PORT_I = 0;
    localparam int unsigned PORT_D = 1;

    localparam int unsigned DEF_MEM_LAT    = 2;
    localparam int unsigned DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, data port and memory-side signals around the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_addr, mem_wdata, mem_read, mem_write
    );

    // Pipeline / memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_addr, mem_wdata, mem_read, mem_write
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Loadable down-counter tracking the remaining busy cycles of a memory access.
module mem_arb_timer #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int unsigned CW = $clog2(MEM_LAT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CW'(MEM_LAT - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and data; data has priority
// except when fetch has been passed over STARVE_MAX times in a row.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic [DATA_W-1:0] if_rdata_c, d_rdata_c;

    logic busy, done, lat_zero;
    logic req_i, req_d, grant_i, grant_d, grant, grant_port;
    logic if_valid_c, d_valid_c;

    mem_arb_timer #(
        .MEM_LAT(MEM_LAT)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (grant),
        .dec  (busy),
        .zero (lat_zero)
    );

    always_comb begin
        busy = (state_q != StIdle);
        done = busy && lat_zero;
        // The port just served is masked so the other one gets the completion edge
        req_i = bus.if_req && !(done && (state_q == StBusyI));
        req_d = bus.d_req && !(done && (state_q == StBusyD));
        grant_d = (!busy || done) && req_d && !(req_i && (starve_q == SW'(STARVE_MAX)));
        grant_i = (!busy || done) && req_i && !grant_d;
        grant = grant_i || grant_d;
        grant_port = grant_d ? 1'(PORT_D) : 1'(PORT_I);

        if_valid_c = done && (state_q == StBusyI);
        d_valid_c  = done && (state_q == StBusyD);
        if_rdata_c = if_valid_c ? bus.mem_rdata : if_rdata_q;
        d_rdata_c  = (d_valid_c && mem_read_q) ? bus.mem_rdata : d_rdata_q;
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;

        if (grant) begin
            if (grant_port == 1'(PORT_D)) begin
                state_d     = StBusyD;
                mem_addr_d  = bus.d_addr;
                mem_wdata_d = bus.d_wdata;
                mem_read_d  = !bus.d_we;
                mem_write_d = bus.d_we;
                if (bus.if_req && (starve_q != SW'(STARVE_MAX))) begin
                    starve_d = starve_q + 1'b1;
                end
            end else begin
                state_d     = StBusyI;
                mem_addr_d  = bus.if_addr;
                mem_read_d  = 1'b1;
                mem_write_d = 1'b0;
                starve_d    = '0;
            end
        end else if (done) begin
            state_d     = StIdle;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            if_rdata_q  <= if_rdata_c;
            d_rdata_q   <= d_rdata_c;
        end
    end

    assign bus.if_valid  = if_valid_c;
    assign bus.d_valid   = d_valid_c;
    assign bus.if_rdata  = if_rdata_c;
    assign bus.d_rdata   = d_rdata_c;
    assign bus.if_stall  = bus.if_req & ~if_valid_c;
    assign bus.d_stall   = bus.d_req & ~d_valid_c;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;

endmodule
